// File: rtl/seg7_pkg.sv
// Shared constants for the scrolling seven-segment controller: FSM encoding,
// blank levels and the hex glyph table (segments a..g on bits 6..0).
package seg7_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   localparam logic [3:0] GROUNDS_OFF = 4'b1111;
   localparam logic [6:0] SEG_BLANK   = 7'h00;

   // Index 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0
   localparam logic [15:0][6:0] GLYPHS = {
      7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
      7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
   };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to seven-segment glyph lookup.
module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = GLYPHS[nibble];

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// Loadable 4-digit multiplexed seven-segment sequencer: buffers a hex message,
// cycles the digit commons and scrolls messages longer than the display.
module seg7_scroll_ctrl
   import seg7_pkg::*;
#(
   parameter int MUX_W     = 16,
   parameter int SCROLL_W  = 26,
   parameter int MSG_DEPTH = 16
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_valid,
   input  logic [3:0] wr_data,
   input  logic       wr_last,
   output logic       wr_ready,
   input  logic       stop,
   output logic       busy,
   output logic [3:0] grounds,
   output logic [6:0] display
);

   localparam int PTR_W = $clog2(MSG_DEPTH);
   localparam int LEN_W = PTR_W + 1;

   state_t              state, state_nxt;
   logic [3:0]          msg [MSG_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    head;
   logic [LEN_W-1:0]    len;
   logic [1:0]          dsel;
   logic [MUX_W-1:0]    mux_cnt;
   logic [SCROLL_W-1:0] scroll_cnt;

   logic                wr_fire, wr_end, show_run, mux_tick, scroll_tick;
   logic [1:0]          off_p0;
   logic [LEN_W-1:0]    idx_sum_p0;
   logic                wrap_p0;
   logic [PTR_W-1:0]    idx_p0;
   logic                blank_p0;
   logic [6:0]          glyph_p0;
   logic [3:0]          grounds_p1;
   logic [6:0]          display_p1;

   assign wr_fire     = (state == ST_IDLE) && wr_valid;
   assign wr_end      = wr_fire && (wr_last || (wr_ptr == PTR_W'(MSG_DEPTH - 1)));
   assign show_run    = (state == ST_SHOW) && !stop;
   assign mux_tick    = (state == ST_SHOW) && (mux_cnt == '1);
   assign scroll_tick = show_run && (len > LEN_W'(4)) && (scroll_cnt == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_IDLE) begin
         if (wr_end) state_nxt = ST_SHOW;
      end else begin
         if (stop) state_nxt = ST_IDLE;
      end
   end

   always_comb begin
      wr_ready = (state == ST_IDLE);
      busy     = (state == ST_SHOW);
   end

   // Message bookkeeping; the final write arms a fresh scroll from the head
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         len        <= '0;
         head       <= '0;
         scroll_cnt <= '0;
      end else if (wr_fire) begin
         wr_ptr <= wr_ptr + 1'b1;
         if (wr_end) begin
            len        <= LEN_W'(wr_ptr) + 1'b1;
            head       <= '0;
            scroll_cnt <= '0;
         end
      end else if (state == ST_SHOW) begin
         if (stop) begin
            wr_ptr <= '0;
            len    <= '0;
            head   <= '0;
         end else begin
            scroll_cnt <= scroll_cnt + 1'b1;
            if (scroll_tick)
               head <= (LEN_W'(head) == len - 1'b1) ? '0 : head + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mux_cnt <= '0;
         dsel    <= '0;
      end else if (state == ST_SHOW) begin
         mux_cnt <= mux_cnt + 1'b1;
         if (mux_tick) dsel <= dsel + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) msg[wr_ptr] <= wr_data;
   end

   // Stage p0: slot offset -> circular message index -> glyph
   always_comb begin
      off_p0     = 2'd3 - dsel;
      idx_sum_p0 = LEN_W'(head) + LEN_W'(off_p0);
      wrap_p0    = (idx_sum_p0 >= len);
      idx_p0     = PTR_W'(wrap_p0 ? idx_sum_p0 - len : idx_sum_p0);
      blank_p0   = (LEN_W'(off_p0) >= len);
   end

   seg7_decoder u_dec (
      .nibble (msg[idx_p0]),
      .glyph  (glyph_p0)
   );

   // Stage p1: registered pin drivers, blanked whenever the display is not running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grounds_p1 <= GROUNDS_OFF;
         display_p1 <= SEG_BLANK;
      end else if (show_run && !blank_p0) begin
         grounds_p1 <= ~(4'b0001 << dsel);
         display_p1 <= glyph_p0;
      end else begin
         grounds_p1 <= GROUNDS_OFF;
         display_p1 <= SEG_BLANK;
      end
   end

   assign grounds = grounds_p1;
   assign display = display_p1;

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Directed bench for seg7_scroll_ctrl with short prescalers: table of timed
// output expectations per scenario plus hand-written load/stop/reset sequences.
module tb_seg7_scroll_ctrl;

   logic       clk = 1'b0;
   logic       rst, wr_valid, wr_last, stop;
   logic [3:0] wr_data;
   logic       wr_ready, busy;
   logic [3:0] grounds;
   logic [6:0] display;

   int cyc    = 0;
   int e0     = 0;
   int checks = 0;
   int errors = 0;

   logic [3:0] ld [16];

   typedef struct {
      int         scen;
      int         at;
      logic [3:0] g;
      logic [6:0] d;
   } vec_t;
   vec_t tbl[$];

   seg7_scroll_ctrl #(.MUX_W(2), .SCROLL_W(5), .MSG_DEPTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_last  (wr_last),
      .wr_ready (wr_ready),
      .stop     (stop),
      .busy     (busy),
      .grounds  (grounds),
      .display  (display)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_edge(input int k);
      if (cyc > e0 + k) begin
         checks++;
         errors++;
         $display("FAIL schedule: at cycle %0d expected %0d", cyc - e0, k);
      end
      while (cyc < e0 + k) @(negedge clk);
   endtask

   task automatic run_table(input int s);
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].scen == s) begin
            wait_edge(tbl[i].at);
            chk($sformatf("s%0d@%0d grounds", s, tbl[i].at), grounds, tbl[i].g);
            chk($sformatf("s%0d@%0d display", s, tbl[i].at), display, tbl[i].d);
         end
      end
   endtask

   task automatic load(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wr_valid = 1'b1;
         wr_data  = ld[i];
         wr_last  = (i == n - 1);
      end
      @(negedge clk);
      e0       = cyc;
      wr_valid = 1'b0;
      wr_last  = 1'b0;
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; wr_valid = 1'b0; wr_data = 4'h0; wr_last = 1'b0; stop = 1'b0;

      // scenario 0: message 1,2,3 (len 3, rightmost slot blank, never scrolls)
      tbl.push_back('{0,   2, 4'b1111, 7'h00});
      tbl.push_back('{0,   6, 4'b1101, 7'h79});
      tbl.push_back('{0,  10, 4'b1011, 7'h6D});
      tbl.push_back('{0,  14, 4'b0111, 7'h30});
      tbl.push_back('{0, 258, 4'b1111, 7'h00});
      tbl.push_back('{0, 262, 4'b1101, 7'h79});
      tbl.push_back('{0, 266, 4'b1011, 7'h6D});
      tbl.push_back('{0, 270, 4'b0111, 7'h30});
      // scenario 1: A,2,1,0,2,F window A210 -> 2102 -> ... -> A210
      tbl.push_back('{1,   2, 4'b1110, 7'h7E});
      tbl.push_back('{1,   6, 4'b1101, 7'h30});
      tbl.push_back('{1,  10, 4'b1011, 7'h6D});
      tbl.push_back('{1,  14, 4'b0111, 7'h77});
      tbl.push_back('{1,  32, 4'b0111, 7'h77});
      tbl.push_back('{1,  33, 4'b1110, 7'h6D});
      tbl.push_back('{1,  34, 4'b1110, 7'h6D});
      tbl.push_back('{1,  38, 4'b1101, 7'h7E});
      tbl.push_back('{1,  42, 4'b1011, 7'h30});
      tbl.push_back('{1,  46, 4'b0111, 7'h6D});
      tbl.push_back('{1, 194, 4'b1110, 7'h7E});
      tbl.push_back('{1, 198, 4'b1101, 7'h30});
      tbl.push_back('{1, 202, 4'b1011, 7'h6D});
      tbl.push_back('{1, 206, 4'b0111, 7'h77});
      // scenario 2: 16 nibbles 3,4,5,...,2 with an ignored 17th write of 9
      tbl.push_back('{2,   2, 4'b1110, 7'h5F});
      tbl.push_back('{2,   6, 4'b1101, 7'h5B});
      tbl.push_back('{2,  10, 4'b1011, 7'h33});
      tbl.push_back('{2,  14, 4'b0111, 7'h79});
      tbl.push_back('{2,  46, 4'b0111, 7'h33});
      tbl.push_back('{2,  50, 4'b1110, 7'h70});
      // scenario 3: 5,6 after stop
      tbl.push_back('{3,   2, 4'b1111, 7'h00});
      tbl.push_back('{3,   6, 4'b1111, 7'h00});
      tbl.push_back('{3,  10, 4'b1011, 7'h5F});
      tbl.push_back('{3,  14, 4'b0111, 7'h5B});
      // scenario 4: single 8 after mid-show reset
      tbl.push_back('{4,   2, 4'b1111, 7'h00});
      tbl.push_back('{4,   6, 4'b1111, 7'h00});
      tbl.push_back('{4,  10, 4'b1111, 7'h00});
      tbl.push_back('{4,  14, 4'b0111, 7'h7F});

      // asynchronous reset before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("reset grounds", grounds, 4'b1111);
      chk("reset display", display, 7'h00);
      chk("reset wr_ready", wr_ready, 1'b1);
      chk("reset busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      ld[0] = 4'h1; ld[1] = 4'h2; ld[2] = 4'h3;
      load(3);
      chk("s0 busy", busy, 1'b1);
      chk("s0 wr_ready", wr_ready, 1'b0);
      run_table(0);
      begin
         int bad = 0;
         for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (!(grounds inside {4'b1111, 4'b0111, 4'b1011, 4'b1101})) bad++;
         end
         chk("s0 grounds legal", bad, 0);
      end

      pulse_rst();
      ld[0] = 4'hA; ld[1] = 4'h2; ld[2] = 4'h1; ld[3] = 4'h0; ld[4] = 4'h2; ld[5] = 4'hF;
      load(6);
      run_table(1);
      // stop coincides with the scroll tick at edge 224
      wait_edge(223);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop busy", busy, 1'b0);
      chk("stop wr_ready", wr_ready, 1'b1);
      chk("stop grounds", grounds, 4'b1111);
      chk("stop display", display, 7'h00);

      ld[0] = 4'h5; ld[1] = 4'h6;
      load(2);
      run_table(3);
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop2 busy", busy, 1'b0);

      pulse_rst();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 15) begin
            chk("s2 ready before 16th", wr_ready, 1'b1);
            chk("s2 idle before 16th", busy, 1'b0);
         end
         wr_valid = 1'b1;
         wr_data  = 4'(i + 3);
         wr_last  = 1'b0;
      end
      @(negedge clk);
      e0 = cyc;
      chk("s2 wr_ready after 16th", wr_ready, 1'b0);
      chk("s2 busy after 16th", busy, 1'b1);
      wr_data = 4'h9;
      @(negedge clk);
      wr_valid = 1'b0;
      run_table(2);

      // asynchronous reset in the middle of a clock period while showing
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst grounds", grounds, 4'b1111);
      chk("midrst display", display, 7'h00);
      chk("midrst busy", busy, 1'b0);
      chk("midrst wr_ready", wr_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      ld[0] = 4'h8;
      load(1);
      run_table(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
